// File: rtl/sram_access_ctrl_if.sv
// Request/grant channels for the SRAM access controller: two read ports and one write port.
interface sram_access_ctrl_if #(
    parameter int unsigned ADDR_W = 7
) ();
    logic              rd0_req;
    logic [ADDR_W-1:0] rd0_addr;
    logic              rd0_gnt;
    logic              rd1_req;
    logic [ADDR_W-1:0] rd1_addr;
    logic              rd1_gnt;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_gnt;

    modport master (
        output rd0_req, rd0_addr, rd1_req, rd1_addr, wr_req, wr_addr,
        input  rd0_gnt, rd1_gnt, wr_gnt
    );

    modport slave (
        input  rd0_req, rd0_addr, rd1_req, rd1_addr, wr_req, wr_addr,
        output rd0_gnt, rd1_gnt, wr_gnt
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// SRAM wordline access controller: arbitrates rd0/rd1/write onto two decoder addresses.
// Optional bitline precharge cycle before each access is enabled by SRAM_ACC_PRECHARGE_EN.
module sram_access_ctrl #(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_access_ctrl_if.slave bus,
    output logic              precharge,
    output logic [ADDR_W-1:0] address_1,
    output logic [ADDR_W-1:0] address_2,
    output logic [1:0]        read_enable,
    output logic              write_enable,
    output logic              rd0_done,
    output logic              rd1_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1
`ifdef SRAM_ACC_PRECHARGE_EN
        ,
        ST_PRE  = 2'd2
`endif
    } state_e;

    state_e            r_state, w_state_nxt;
    logic              r_defer, w_defer_nxt;
    logic              r_pre, w_pre_nxt;
    logic [1:0]        r_re, w_re_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_a1, w_a1_nxt;
    logic [ADDR_W-1:0] r_a2, w_a2_nxt;
    logic              r_rd0_done, r_rd1_done;
`ifdef SRAM_ACC_PRECHARGE_EN
    logic [1:0]        r_lat_re, w_lat_re_nxt;
    logic              r_lat_we, w_lat_we_nxt;
    logic [ADDR_W-1:0] r_lat_a1, w_lat_a1_nxt;
    logic [ADDR_W-1:0] r_lat_a2, w_lat_a2_nxt;
`endif

    logic              w_accept;
    logic              w_gnt_wr, w_gnt_rd0, w_gnt_rd1, w_any_gnt;
    logic [ADDR_W-1:0] w_a1_sel, w_a1_new, w_a2_new;

    // Grants are gated by rst_n so they drop the instant reset asserts.
    assign w_accept  = rst_n && ((r_state == ST_IDLE) || (r_state == ST_ACC));
    assign w_gnt_wr  = w_accept && bus.wr_req && !(bus.rd0_req && r_defer);
    assign w_gnt_rd0 = w_accept && bus.rd0_req && !w_gnt_wr;
    assign w_gnt_rd1 = w_accept && bus.rd1_req && !(w_gnt_wr && (bus.rd1_addr == bus.wr_addr));
    assign w_any_gnt = w_gnt_wr || w_gnt_rd0 || w_gnt_rd1;
    assign w_a1_sel  = w_gnt_wr ? bus.wr_addr : bus.rd0_addr;
    assign w_a1_new  = (w_gnt_wr || w_gnt_rd0) ? w_a1_sel : r_a1;
    assign w_a2_new  = w_gnt_rd1 ? bus.rd1_addr : r_a2;

    assign bus.wr_gnt  = w_gnt_wr;
    assign bus.rd0_gnt = w_gnt_rd0;
    assign bus.rd1_gnt = w_gnt_rd1;

    always_comb begin
        w_state_nxt = r_state;
        w_defer_nxt = r_defer;
        w_pre_nxt   = 1'b0;
        w_re_nxt    = 2'b00;
        w_we_nxt    = 1'b0;
        w_a1_nxt    = r_a1;
        w_a2_nxt    = r_a2;
`ifdef SRAM_ACC_PRECHARGE_EN
        w_lat_re_nxt = r_lat_re;
        w_lat_we_nxt = r_lat_we;
        w_lat_a1_nxt = r_lat_a1;
        w_lat_a2_nxt = r_lat_a2;
`endif
        case (r_state)
            ST_IDLE, ST_ACC: begin
                // A denied rd0 gets priority over the write at the next accept.
                if (w_gnt_rd0)
                    w_defer_nxt = 1'b0;
                else if (bus.rd0_req && w_gnt_wr)
                    w_defer_nxt = 1'b1;
                if (w_any_gnt) begin
`ifdef SRAM_ACC_PRECHARGE_EN
                    w_state_nxt  = ST_PRE;
                    w_pre_nxt    = 1'b1;
                    w_lat_re_nxt = {w_gnt_rd1, w_gnt_rd0};
                    w_lat_we_nxt = w_gnt_wr;
                    w_lat_a1_nxt = w_a1_new;
                    w_lat_a2_nxt = w_a2_new;
`else
                    w_state_nxt  = ST_ACC;
                    w_re_nxt     = {w_gnt_rd1, w_gnt_rd0};
                    w_we_nxt     = w_gnt_wr;
                    w_a1_nxt     = w_a1_new;
                    w_a2_nxt     = w_a2_new;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef SRAM_ACC_PRECHARGE_EN
            ST_PRE: begin
                w_state_nxt = ST_ACC;
                w_re_nxt    = r_lat_re;
                w_we_nxt    = r_lat_we;
                w_a1_nxt    = r_lat_a1;
                w_a2_nxt    = r_lat_a2;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_defer    <= 1'b0;
            r_pre      <= 1'b0;
            r_re       <= 2'b00;
            r_we       <= 1'b0;
            r_a1       <= '0;
            r_a2       <= '0;
            r_rd0_done <= 1'b0;
            r_rd1_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_defer    <= w_defer_nxt;
            r_pre      <= w_pre_nxt;
            r_re       <= w_re_nxt;
            r_we       <= w_we_nxt;
            r_a1       <= w_a1_nxt;
            r_a2       <= w_a2_nxt;
            r_rd0_done <= r_re[0];
            r_rd1_done <= r_re[1];
        end
    end

`ifdef SRAM_ACC_PRECHARGE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_re <= 2'b00;
            r_lat_we <= 1'b0;
            r_lat_a1 <= '0;
            r_lat_a2 <= '0;
        end else begin
            r_lat_re <= w_lat_re_nxt;
            r_lat_we <= w_lat_we_nxt;
            r_lat_a1 <= w_lat_a1_nxt;
            r_lat_a2 <= w_lat_a2_nxt;
        end
    end
`endif

    assign precharge    = r_pre;
    assign read_enable  = r_re;
    assign write_enable = r_we;
    assign address_1    = r_a1;
    assign address_2    = r_a2;
    assign rd0_done     = r_rd0_done;
    assign rd1_done     = r_rd1_done;

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 7, wordline address width; WL count is 2**ADDR_W = 128.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 rd0_req  input  1  read port 0 request; held until granted.
REQ-005 rd0_addr  input  ADDR_W  read port 0 row address.
REQ-006 rd0_gnt  output  1  combinational grant; handshake completes on an edge with rd0_req & rd0_gnt.
REQ-007 rd1_req / rd1_addr / rd1_gnt  as REQ-004..006, read port 1.
REQ-008 wr_req / wr_addr / wr_gnt  as REQ-004..006, write port.
REQ-009 precharge  output  1  bitline precharge strobe.
REQ-010 address_1  output  ADDR_W  decoder address 1; carries the write or rd0 address.
REQ-011 address_2  output  ADDR_W  decoder address 2; carries the rd1 address.
REQ-012 read_enable  output  2  decoder read enables; bit0 = rd0, bit1 = rd1.
REQ-013 write_enable  output  1  decoder write enable.
REQ-014 rd0_done / rd1_done  output  1  one-cycle pulse; sense data valid for that port.

Function
REQ-015 FSM states: IDLE, PRE, ACC; requests are evaluated only in IDLE and ACC (accept cycles).
REQ-016 Accept cycle with at least one request granted -> PRE (ACC when precharge is compiled out); otherwise -> IDLE.
REQ-017 PRE lasts exactly one cycle, with precharge=1, and always transitions to ACC.
REQ-018 ACC lasts exactly one cycle and drives the latched addresses and enables to the decoder.
REQ-019 Outside ACC: read_enable=2'b00 and write_enable=0; address_1 and address_2 hold their last value.
REQ-020 Write and rd0 share address_1, so at most one of them is granted per accept cycle.
REQ-021 Write has priority over rd0, except when defer_rd0 is set; then rd0 wins and write waits.
REQ-022 defer_rd0 sets when rd0_req is denied because of a write; it clears when rd0 is granted.
REQ-023 rd1 is denied when a write is granted in the same cycle and rd1_addr == wr_addr; rd1 retries next accept cycle.
REQ-024 rd0 and rd1 to the same address are both granted.
REQ-025 Grants are asserted only in accept cycles and are zero in PRE.
REQ-026 Latency with precharge: grant at edge N, PRE in cycle N+1, ACC in cycle N+2, done pulse in cycle N+3.
REQ-027 Latency without precharge: ACC in cycle N+1, done in cycle N+2.
REQ-028 rdX_done is registered and equals the read_enable bit of the previous cycle.
REQ-029 Back-to-back operation: requests present in ACC are accepted without returning to IDLE.
REQ-030 No grant is issued for an address >= 2**ADDR_W; this cannot occur by width, so no check is needed.

Reset
REQ-031 While rst_n=0, and immediately on its assertion:
- state=IDLE, defer_rd0=0
- all grants, precharge, enables and done outputs = 0
- address_1 = address_2 = 0
REQ-032 Reset asserted mid-PRE or mid-ACC aborts the access; no done pulse follows.
REQ-033 The first accept cycle is the first rising edge after rst_n deasserts.

Configuration
REQ-034 Macro SRAM_ACC_PRECHARGE_EN: when defined, the PRE state exists and REQ-017 and REQ-026 apply.
REQ-035 When SRAM_ACC_PRECHARGE_EN is undefined:
- the PRE state is removed
- precharge is tied to 0
- accept goes directly to ACC (REQ-027)

Verification
REQ-036 Precharge on; single rd0_req with addr 7'h3C -> rd0_gnt=1 at cycle N; precharge=1 at N+1; address_1=7'h3C and read_enable=2'b01 at N+2; rd0_done=1 at N+3.
REQ-037 wr_req addr 7'h4F and rd1_req addr 7'h3C together -> both granted; at ACC, address_1=7'h4F, address_2=7'h3C, write_enable=1, read_enable=2'b10.
REQ-038 wr_req and rd0_req held continuously:
- first access is the write, and defer_rd0 sets
- second access is rd0
- accesses then alternate W, R0, W, R0
REQ-039 wr_req and rd1_req both with addr 7'h11 -> only wr_gnt=1; rd1 is granted at the next accept cycle.
REQ-040 rst_n driven low during ACC -> read_enable, write_enable, precharge and grants go to 0 asynchronously; no rd0_done/rd1_done pulse; state=IDLE.
REQ-041 Build without SRAM_ACC_PRECHARGE_EN; rd0 and rd1 both at addr 7'h05 -> ACC at N+1 with read_enable=2'b11; precharge stays 0; both done pulses at N+2.
